alu_count_decode_unit: RTL and testbench
========================================

Name: alu_count_decode_unit

Overview:
- Small datapath utility block combining three functions under one clock domain.
- A purely combinational 4-bit ALU with zero, carry and overflow flags.
- A combinational 3-to-8 decoder with enable.
- A registered 3-bit down counter advanced by an enable/tick input.
- Used as a bring-up and board-demo block; counter output drives displays, decoder drives LEDs.

Parameters:
- none (widths fixed: ALU 4 bits, counter 3 bits, decoder 3-to-8)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- alu_fnselec  input  3  ALU operation select
- alu_a  input  4  operand A (two's complement where signed)
- alu_b  input  4  operand B
- alu_res  output  4  ALU result
- alu_zero  output  1  high when alu_res == 0
- alu_overflow  output  1  signed overflow (add/sub only)
- alu_carry  output  1  carry-out (add/sub only)
- dec_x  input  3  decoder select
- dec_en  input  1  decoder enable
- dec_y  output  8  one-hot decoder output
- counter_en  input  1  count-step enable (one decrement per clk edge while high)
- counter_out  output  3  down-counter value

Behaviour:
- ALU and decoder are combinational: no latency, independent of clk and rst.
- ALU opcodes (alu_fnselec):
  - 000 ADD: {carry,res} = a + b.
  - 001 SUB: {carry,res} = a + ~b + 1; carry=1 means no borrow.
  - 010 NOT: res = ~a.
  - 011 AND: res = a & b.
  - 100 OR: res = a | b.
  - 101 XOR: res = a ^ b.
  - 110 SLT (signed less-than): res = {3'b000, lt}, where lt = sign(a-b) XOR overflow(a-b).
  - 111 EQ: res = {3'b000, a==b}.
- ADD overflow = (a[3]==b[3]) && (res[3]!=a[3]).
- SUB overflow = (a[3]!=b[3]) && (res[3]!=a[3]).
- alu_carry and alu_overflow are 0 for opcodes 010..111. SLT/EQ compute overflow internally but do not export it.
- alu_zero = (alu_res == 4'b0000) for every opcode, including SLT/EQ (EQ true gives zero=0).
- Decoder: dec_en=0 gives dec_y=8'h00. dec_en=1 gives dec_y = 8'h01 << dec_x; exactly one bit set.
- Counter:
  - rst high forces counter_out=3'd7 immediately (async) and holds it while asserted.
  - After rst release, each rising clk with counter_en=1 gives counter_out <= counter_out - 1.
  - Wrap-around 0 -> 7, no terminal flag.
  - counter_en=0 holds the value.
  - Reset mid-count wins over counter_en on the same edge.
- Outputs after reset: counter_out=7. ALU and decoder outputs reflect their current inputs (not reset-dependent).
- No X propagation: every opcode, including unused combinations, yields defined outputs.

Decomposition:
- Shared package alu_pkg: 3-bit opcode localparams (OP_ADD=0, OP_SUB=1, OP_NOT=2, OP_AND=3, OP_OR=4, OP_XOR=5, OP_SLT=6, OP_EQ=7) and counter reset constant CNT_RST=3'd7.
- One natural sub-module: alu4_core, holding the combinational ALU with its flags and a shared adder/subtractor.
- Decoder and counter stay inline in the top.

Test Plan:
- ADD a=0111,b=0001 -> res=1000, overflow=1, carry=0, zero=0. ADD a=1111,b=0001 -> res=0000, carry=1, overflow=0, zero=1.
- SUB a=0011,b=0101 -> res=1110, carry=0, overflow=0. SUB a=1000,b=0001 -> res=0111, carry=1, overflow=1.
- SLT a=1000(-8),b=0111(7) -> res=0001. SLT a=0111,b=1000 -> res=0000, zero=1. EQ a=b=0101 -> res=0001, zero=0. NOT a=1010 -> res=0101. XOR a=1100,b=1010 -> res=0110.
- Decoder: dec_en=1, dec_x=5 -> dec_y=0010_0000. Sweep x=0..7 -> single bit walks 01..80. dec_en=0, any x -> 00.
- Counter: pulse rst -> 7. counter_en=1 for 8 clocks -> 6,5,4,3,2,1,0,7. counter_en=0 for 3 clocks -> value held.
- Assert rst asynchronously between edges while counting at 3 -> counter_out=7 before next edge. Release with counter_en=1 -> next edge gives 6.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU/counter/decoder bring-up block:
// ALU opcodes and the counter reset value.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_NOT = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_SLT = 3'd6;
    localparam logic [2:0] OP_EQ  = 3'd7;

    localparam logic [2:0] CNT_RST = 3'd7;

endpackage

// File: rtl/alu4_core.sv
// Combinational 4-bit ALU with zero/carry/overflow flags.
// One adder serves ADD, SUB, SLT and EQ; only ADD/SUB export carry and overflow.
module alu4_core
    import alu_pkg::*;
(
    input  logic [2:0] fnselec,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] res,
    output logic       zero,
    output logic       overflow,
    output logic       carry
);

    logic              sub_sel;
    logic [3:0]        b_eff;
    logic [4:0]        sum;
    logic signed [3:0] sum_s;
    logic              ovf_int;
    logic              lt;

    // Everything except ADD runs the adder as a subtractor (a + ~b + 1).
    assign sub_sel = (fnselec != OP_ADD);
    assign b_eff   = sub_sel ? ~b : b;
    assign sum     = {1'b0, a} + {1'b0, b_eff} + {4'b0000, sub_sel};
    assign sum_s   = sum[3:0];

    // With b already inverted for subtraction, one formula covers both overflows.
    assign ovf_int = (a[3] == b_eff[3]) && (sum_s[3] != a[3]);
    assign lt      = sum_s[3] ^ ovf_int;

    always_comb begin
        res      = 4'b0000;
        overflow = 1'b0;
        carry    = 1'b0;
        case (fnselec)
            OP_ADD, OP_SUB: begin
                res      = sum[3:0];
                overflow = ovf_int;
                carry    = sum[4];
            end
            OP_NOT:  res = ~a;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_SLT:  res = {3'b000, lt};
            OP_EQ:   res = {3'b000, (a == b)};
            default: res = 4'b0000;
        endcase
    end

    assign zero = (res == 4'b0000);

endmodule

// File: rtl/alu_count_decode_unit.sv
// Bring-up/demo block: combinational 4-bit ALU, 3-to-8 decoder with enable,
// and a 3-bit down counter stepped by counter_en.
module alu_count_decode_unit
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] alu_fnselec,
    input  logic [3:0] alu_a,
    input  logic [3:0] alu_b,
    output logic [3:0] alu_res,
    output logic       alu_zero,
    output logic       alu_overflow,
    output logic       alu_carry,
    input  logic [2:0] dec_x,
    input  logic       dec_en,
    output logic [7:0] dec_y,
    input  logic       counter_en,
    output logic [2:0] counter_out
);

    alu4_core u_alu (
        .fnselec  (alu_fnselec),
        .a        (alu_a),
        .b        (alu_b),
        .res      (alu_res),
        .zero     (alu_zero),
        .overflow (alu_overflow),
        .carry    (alu_carry)
    );

    assign dec_y = dec_en ? (8'h01 << dec_x) : 8'h00;

    // Natural 3-bit wrap takes 0 back to 7; reset outranks counter_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter_out <= CNT_RST;
        end else if (counter_en) begin
            counter_out <= counter_out - 3'd1;
        end
    end

endmodule

// File: tb/tb_alu_count_decode_unit.sv
// Scoreboard bench: expected values are queued when stimulus is driven and
// popped against the DUT outputs once they are due.
module tb_alu_count_decode_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] alu_fnselec;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_res;
    logic       alu_zero;
    logic       alu_overflow;
    logic       alu_carry;
    logic [2:0] dec_x;
    logic       dec_en;
    logic [7:0] dec_y;
    logic       counter_en;
    logic [2:0] counter_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        int         kind;   // 0 alu {res,zero,ovf,carry}, 1 decoder, 2 counter
        logic [7:0] exp;
    } sb_t;
    sb_t sbq[$];

    logic [2:0] cnt_model;

    alu_count_decode_unit dut (
        .clk          (clk),
        .rst          (rst),
        .alu_fnselec  (alu_fnselec),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_res      (alu_res),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .alu_carry    (alu_carry),
        .dec_x        (dec_x),
        .dec_en       (dec_en),
        .dec_y        (dec_y),
        .counter_en   (counter_en),
        .counter_out  (counter_out)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int ua, ub, sa, sb, r;
        logic [3:0] res;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 7) ? ua - 16 : ua;
        sb = (ub > 7) ? ub - 16 : ub;
        c = 1'b0;
        v = 1'b0;
        res = 4'b0000;
        case (op)
            3'd0: begin
                r = ua + ub;
                res = r[3:0];
                c = (r > 15);
                v = ((sa + sb) > 7) || ((sa + sb) < -8);
            end
            3'd1: begin
                r = ua - ub + 16;
                res = r[3:0];
                c = (ua >= ub);
                v = ((sa - sb) > 7) || ((sa - sb) < -8);
            end
            3'd2: res = 4'hF - a;
            3'd3: for (int i = 0; i < 4; i++) res[i] = a[i] && b[i];
            3'd4: for (int i = 0; i < 4; i++) res[i] = a[i] || b[i];
            3'd5: for (int i = 0; i < 4; i++) res[i] = (a[i] != b[i]);
            3'd6: res = (sa < sb) ? 4'd1 : 4'd0;
            default: res = (ua == ub) ? 4'd1 : 4'd0;
        endcase
        return {res, (res == 4'd0), v, c};
    endfunction

    task automatic compare(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check();
        sb_t e;
        logic [7:0] obs;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sbq.pop_front();
        case (e.kind)
            0:       obs = {1'b0, alu_res, alu_zero, alu_overflow, alu_carry};
            1:       obs = dec_y;
            default: obs = {5'b0, counter_out};
        endcase
        compare(e.tag, obs, e.exp);
    endtask

    // use_model=1 derives expectation from alu_ref, else the given constant is used
    task automatic alu_step(input string tag, input logic [2:0] op, input logic [3:0] a,
                            input logic [3:0] b, input logic [6:0] exp, input bit use_model);
        alu_fnselec = op;
        alu_a = a;
        alu_b = b;
        sbq.push_back('{tag, 0, {1'b0, (use_model ? alu_ref(op, a, b) : exp)}});
        #1;
        pop_check();
    endtask

    task automatic dec_step(input string tag, input logic en, input logic [2:0] x);
        logic [7:0] e;
        e = 8'h00;
        for (int i = 0; i < 8; i++) if (en && (i == int'(x))) e[i] = 1'b1;
        dec_en = en;
        dec_x = x;
        sbq.push_back('{tag, 1, e});
        #1;
        pop_check();
    endtask

    task automatic cnt_step(input string tag, input logic en);
        counter_en = en;
        if (en) cnt_model = cnt_model - 3'd1;
        sbq.push_back('{tag, 2, {5'b0, cnt_model}});
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        rst = 1'b1;
        alu_fnselec = 3'd0;
        alu_a = 4'd0;
        alu_b = 4'd0;
        dec_x = 3'd0;
        dec_en = 1'b0;
        counter_en = 1'b0;
        cnt_model = 3'd7;

        #12;
        sbq.push_back('{"reset_value", 2, 8'd7});
        pop_check();
        @(negedge clk);
        rst = 1'b0;

        // ALU directed cases with hand-derived {res,zero,ovf,carry}
        alu_step("add_ovf",   3'd0, 4'b0111, 4'b0001, {4'b1000, 1'b0, 1'b1, 1'b0}, 1'b0);
        alu_step("add_carry", 3'd0, 4'b1111, 4'b0001, {4'b0000, 1'b1, 1'b0, 1'b1}, 1'b0);
        alu_step("sub_borrow",3'd1, 4'b0011, 4'b0101, {4'b1110, 1'b0, 1'b0, 1'b0}, 1'b0);
        alu_step("sub_ovf",   3'd1, 4'b1000, 4'b0001, {4'b0111, 1'b0, 1'b1, 1'b1}, 1'b0);
        alu_step("slt_true",  3'd6, 4'b1000, 4'b0111, {4'b0001, 1'b0, 1'b0, 1'b0}, 1'b0);
        alu_step("slt_false", 3'd6, 4'b0111, 4'b1000, {4'b0000, 1'b1, 1'b0, 1'b0}, 1'b0);
        alu_step("eq_true",   3'd7, 4'b0101, 4'b0101, {4'b0001, 1'b0, 1'b0, 1'b0}, 1'b0);
        alu_step("not",       3'd2, 4'b1010, 4'b0000, {4'b0101, 1'b0, 1'b0, 1'b0}, 1'b0);
        alu_step("xor",       3'd5, 4'b1100, 4'b1010, {4'b0110, 1'b0, 1'b0, 1'b0}, 1'b0);
        alu_step("and",       3'd3, 4'b1100, 4'b1010, {4'b1000, 1'b0, 1'b0, 1'b0}, 1'b0);
        alu_step("or",        3'd4, 4'b1100, 4'b1010, {4'b1110, 1'b0, 1'b0, 1'b0}, 1'b0);

        // Every opcode against random operands via the reference model
        for (int op = 0; op < 8; op++) begin
            for (int k = 0; k < 6; k++) begin
                alu_step($sformatf("alu_rand_op%0d", op), 3'(op),
                         4'($urandom_range(15)), 4'($urandom_range(15)), 7'd0, 1'b1);
            end
        end

        sbq.push_back('{"dec_x5", 1, 8'b0010_0000});
        dec_en = 1'b1;
        dec_x = 3'd5;
        #1;
        pop_check();
        for (int x = 0; x < 8; x++) dec_step($sformatf("dec_walk%0d", x), 1'b1, 3'(x));
        for (int x = 0; x < 8; x++) dec_step($sformatf("dec_off%0d", x), 1'b0, 3'(x));

        @(negedge clk);
        for (int i = 0; i < 8; i++) cnt_step($sformatf("cnt_dec%0d", i), 1'b1);
        for (int i = 0; i < 3; i++) cnt_step($sformatf("cnt_hold%0d", i), 1'b0);
        for (int i = 0; i < 4; i++) cnt_step($sformatf("cnt_to3_%0d", i), 1'b1);

        // Asynchronous reset between edges while counting at 3
        #2;
        rst = 1'b1;
        #1;
        cnt_model = 3'd7;
        sbq.push_back('{"async_rst", 2, {5'b0, cnt_model}});
        pop_check();
        sbq.push_back('{"rst_wins", 2, {5'b0, cnt_model}});
        @(posedge clk);
        #1;
        pop_check();
        #2;
        rst = 1'b0;
        cnt_step("after_release", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
